// File: rtl/hdmi_pkg.sv
// Definitions shared by the TMDS encoder and decoder: the four control tokens
// and the word-alignment state encoding.
package hdmi_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Purely combinational classification and decode of one aligned 10-bit TMDS
// symbol into control-token flags or an 8-bit pixel byte.
module tmds_symbol_decode
    import hdmi_pkg::*;
(
    input  logic [9:0] symbol_i,
    output logic       is_ctrl_o,
    output logic [1:0] ctrl_o,
    output logic [7:0] data_o
);

    logic [7:0] stage1;

    always_comb begin
        is_ctrl_o = 1'b1;
        ctrl_o    = 2'b00;
        case (symbol_i)
            CTRL_TOKEN_00: ctrl_o = 2'b00;
            CTRL_TOKEN_01: ctrl_o = 2'b01;
            CTRL_TOKEN_10: ctrl_o = 2'b10;
            CTRL_TOKEN_11: ctrl_o = 2'b11;
            default:       is_ctrl_o = 1'b0;
        endcase
    end

    // Undo the optional inversion (bit 9), then the XOR/XNOR transition chain (bit 8).
    always_comb begin
        stage1    = symbol_i[9] ? ~symbol_i[7:0] : symbol_i[7:0];
        data_o    = 8'h00;
        data_o[0] = stage1[0];
        for (int i = 1; i < 8; i++) begin
            data_o[i] = symbol_i[8] ? (stage1[i] ^ stage1[i-1])
                                    : ~(stage1[i] ^ stage1[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// Single-channel TMDS receive decoder: hunts word alignment on control-token
// runs, then decodes aligned symbols to pixel data, sync bits and display enable.
module tmds_decoder
    import hdmi_pkg::*;
#(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int LOCK_TIMEOUT  = 4096
) (
    input  logic       i_hdmi_clk,
    input  logic       i_reset,
    input  logic [9:0] i_tmds,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_display_enable,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int RUN_W = $clog2(CTRL_RUN) + 1;
    localparam int WIN_W = $clog2(SEARCH_WINDOW) + 1;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CTRL_RUN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

    logic [19:0]      hist_q;
    logic [9:0]       sym_q, sym_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             de_q, de_d;

    align_state_e     state_q;
    logic             locked_q;
    logic [3:0]       offset_q;
    logic [3:0]       offset_next;
    logic [RUN_W-1:0] run_q, run_next;
    logic [WIN_W-1:0] win_q;
    logic [TO_W-1:0]  to_q;
    logic [1:0]       flush_q;

    logic             lock_hit;
    logic             timeout_hit;
    logic             locked_next;

    logic             sym_is_ctrl;
    logic [1:0]       sym_ctrl;
    logic [7:0]       sym_data;

    tmds_symbol_decode u_symbol_decode (
        .symbol_i  (sym_q),
        .is_ctrl_o (sym_is_ctrl),
        .ctrl_o    (sym_ctrl),
        .data_o    (sym_data)
    );

    // History is {current word, previous word}; the symbol starts offset bits into it.
    always_comb begin
        sym_d = 10'(hist_q >> offset_q);
    end

    always_comb begin
        if (flush_q != 2'd0) begin
            run_next = run_q;
        end else if (sym_is_ctrl) begin
            run_next = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
        end else begin
            run_next = '0;
        end
        lock_hit    = (run_next == RUN_MAX);
        timeout_hit = (state_q == LOCKED) && !lock_hit && (to_q == TO_LAST);
        locked_next = (state_q == LOCKED) ? !timeout_hit : lock_hit;
        offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    end

    // Outputs follow the lock decision made on the same edge, so they stay
    // consistent with o_locked.
    always_comb begin
        data_d = 8'h00;
        ctrl_d = ctrl_q;
        de_d   = 1'b0;
        if (!locked_next) begin
            ctrl_d = 2'b00;
        end else if (sym_is_ctrl) begin
            ctrl_d = sym_ctrl;
        end else begin
            de_d   = 1'b1;
            data_d = sym_data;
        end
    end

    always_ff @(posedge i_hdmi_clk) begin
        if (i_reset) begin
            hist_q <= '0;
            sym_q  <= '0;
            data_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else begin
            hist_q <= {i_tmds, hist_q[19:10]};
            sym_q  <= sym_d;
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            de_q   <= de_d;
        end
    end

    // A slip leaves stale symbols in the pipeline; flush_q masks them for two cycles.
    always_ff @(posedge i_hdmi_clk) begin
        if (i_reset) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            offset_q <= '0;
            run_q    <= '0;
            win_q    <= '0;
            to_q     <= '0;
            flush_q  <= '0;
        end else begin
            flush_q <= (flush_q != 2'd0) ? flush_q - 2'd1 : 2'd0;
            run_q   <= run_next;
            case (state_q)
                SEARCH: begin
                    if (lock_hit) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        win_q    <= '0;
                        to_q     <= '0;
                    end else if (win_q == WIN_LAST) begin
                        offset_q <= offset_next;
                        run_q    <= '0;
                        win_q    <= '0;
                        flush_q  <= 2'd2;
                    end else begin
                        win_q <= win_q + WIN_W'(1);
                    end
                end
                LOCKED: begin
                    if (lock_hit) begin
                        to_q <= '0;
                    end else if (timeout_hit) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        offset_q <= offset_next;
                        run_q    <= '0;
                        win_q    <= '0;
                        to_q     <= '0;
                        flush_q  <= 2'd2;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_data           = data_q;
    assign o_ctrl           = ctrl_q;
    assign o_display_enable = de_q;
    assign o_locked         = locked_q;
    assign o_offset         = offset_q;

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
Receive-side counterpart of the TMDS encoder. Takes raw 10-bit words from a 1:10 deserializer, which may be at an arbitrary bit phase. The block finds word alignment by hunting for control-token runs during blanking, then decodes each aligned symbol back to 8-bit pixel data, 2-bit control (hsync/vsync) and display enable. One instance serves one TMDS channel in an HDMI/DVI receive path.

Parameters:
CTRL_RUN, 8, consecutive control tokens at the current bit offset needed to declare lock.
SEARCH_WINDOW, 4096, cycles spent at one bit offset before slipping to the next; must exceed one video line.
LOCK_TIMEOUT, 4096, cycles allowed in LOCKED without a full CTRL_RUN-long token run before lock is dropped.

Ports:
i_hdmi_clk  input  1  pixel clock; sole clock. Reset is synchronous and active-high on i_hdmi_clk.
i_reset  input  1  synchronous reset, active-high.
i_tmds  input  10  raw deserialized word; bit 0 is the earliest bit on the wire.
o_data  output  8  decoded pixel byte.
o_ctrl  output  2  decoded control bits {c1,c0}.
o_display_enable  output  1  high when o_data is a valid pixel.
o_locked  output  1  word alignment established.
o_offset  output  4  current bit-slip offset, 0..9.

Behaviour:
- Reset values: o_data=0, o_ctrl=0, o_display_enable=0, o_locked=0, o_offset=0, all counters 0, state=SEARCH, history register 0.
- Alignment: a 20-bit history register holds {current word, previous word}. The aligned symbol is bits [offset+9 : offset] of that concatenation.
- Symbol classification:
  - Control tokens: 1101010100 → ctrl 00; 0010101011 → 01; 0101010100 → 10; 1010101011 → 11.
  - Any other symbol is data.
- Data decode:
  - d = w[9] ? ~w[7:0] : w[7:0].
  - out[0] = d[0].
  - For i = 1..7: out[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Latency: fixed 3 i_hdmi_clk cycles from the cycle carrying a symbol's last bit on i_tmds to the corresponding outputs. Stages: history register, registered aligned symbol, registered decode.
- Output rules:
  - While locked, a control token sets o_ctrl to its value, o_display_enable=0 and o_data=0.
  - While locked, a data symbol sets o_display_enable=1 and o_data to the decoded byte; o_ctrl holds its last value.
  - While not locked, o_data=0, o_ctrl=0 and o_display_enable=0, regardless of the symbol.
- FSM SEARCH:
  - run_cnt increments on each control token; a data symbol clears it.
  - win_cnt increments every cycle.
  - run_cnt reaching CTRL_RUN moves the FSM to LOCKED with o_locked=1 on the same edge.
  - Otherwise, win_cnt reaching SEARCH_WINDOW-1 slips the offset: offset+1, wrapping 9→0. The same edge clears run_cnt and win_cnt.
  - After a slip, symbol classification is ignored for 2 cycles (pipeline flush).
  - If lock and slip fall due on the same edge, lock wins and the offset is unchanged.
- FSM LOCKED:
  - run_cnt counts as in SEARCH. to_cnt increments every cycle.
  - run_cnt reaching CTRL_RUN clears to_cnt.
  - to_cnt reaching LOCK_TIMEOUT-1 returns the FSM to SEARCH with o_locked=0. That edge clears all counters and slips the offset by 1.
  - Data symbols never cause loss of lock directly.
- Counters saturate and never wrap: run_cnt at CTRL_RUN, to_cnt at LOCK_TIMEOUT-1. Counter widths are $clog2 of the parameter plus 1.
- Reset asserted mid-operation: all state returns to the reset values on the next edge, with no partial outputs. The pipeline refills within 3 cycles after release.

Decomposition:
- Shared package hdmi_pkg holds:
  - the four 10-bit control-token constants, shared with the encoder side;
  - an enum for the alignment states {SEARCH, LOCKED}.
- One natural sub-module, tmds_symbol_decode. It is purely combinational: 10-bit aligned symbol in; is_ctrl, ctrl[1:0] and data[7:0] out.
- tmds_decoder owns the history register, the offset barrel-select, the counters/FSM and the output registers.

Test Plan:
1. After reset, feed 1101010100 repeatedly at offset 0 → o_locked=1 within CTRL_RUN+3 cycles; o_offset=0, o_ctrl=00, o_display_enable=0.
2. Feed a token stream shifted by 3 bits (bit stream delayed 3) with SEARCH_WINDOW=16 → o_offset steps 0,1,2,3, then lock at offset 3; o_locked never rises at offsets 0–2.
3. After lock, drive a tmds_encoder instance (same clock) with blank rows then data 0x00, 0xFF, 0xA5 and sync pattern ctrl 00/01/10/11:
   - raw 0100000000 decodes to 0x00 and 1000000000 to 0xFF;
   - all bytes match with 3-cycle latency;
   - o_ctrl tracks 00/01/10/11 during blanking.
4. Feed CTRL_RUN-1 tokens, then one data symbol, repeated for SEARCH_WINDOW cycles → no lock; o_offset advances by 1 and wraps 9→0 after 10 windows.
5. While locked, feed only data symbols for LOCK_TIMEOUT cycles (LOCK_TIMEOUT=32) → o_locked falls on cycle 32, o_display_enable drops to 0 and o_offset increments by 1.
6. Assert i_reset for 1 cycle while locked and outputting data → on the next edge all outputs are 0 and o_offset=0; relock follows the scenario 1 timing.
